// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw asynchronous input for use as a clean level.
//   The input passes through a SYNC_STAGES flop synchronizer and then a
//   counter-based debounce FSM. A new level is accepted only after it has been
//   sampled for DEBOUNCE_CYCLES consecutive cycles. Aborted transitions are
//   counted in a saturating glitch counter.
//
// State table:
//   S_LOW    | dout settled low, watching for s=1
//   S_WAIT_H | s went high, counting toward acceptance of a rise
//   S_HIGH   | dout settled high, watching for s=0
//   S_WAIT_L | s went low, counting toward acceptance of a fall
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   din        in   raw asynchronous input
//   dout       out  debounced level (registered)
//   rise       out  one-cycle pulse on dout 0->1 (registered)
//   fall       out  one-cycle pulse on dout 1->0 (registered)
//   stable     out  high when not in a WAIT state
//   glitch_cnt out  saturating count of aborted transitions
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_WIDTH       = 4,
  parameter int unsigned GLITCH_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic                    dout,
  output logic                    rise,
  output logic                    fall,
  output logic                    stable,
  output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    dout_q, dout_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
  logic [GLITCH_WIDTH-1:0] glitch_inc;
  logic                    s;

  // Only the synchronizer chain ever looks at din.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  // Saturating increment: hold once all ones.
  assign glitch_inc = (glitch_q == '1) ? glitch_q : glitch_q + GLITCH_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    unique case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_WAIT_H;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      S_WAIT_H: begin
        if (!s) begin
          state_d  = S_LOW;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_WAIT_L;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      S_WAIT_L: begin
        if (s) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= S_LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;
  assign stable     = (state_q == S_LOW) || (state_q == S_HIGH);

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync. Two instances share the stimulus: one with the
// default parameters and one with a 2-bit glitch counter so saturation is
// reachable quickly. A run-length reference model predicts every cycle's
// outputs; the driver pushes predictions into a queue and a monitor compares.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       dout, rise, fall, stable;
  logic [7:0] glitch_cnt;
  logic       dout2, rise2, fall2, stable2;
  logic [1:0] glitch_cnt2;

  always #5 clk = ~clk;

  debounce_sync u_dut (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .stable(stable),
    .glitch_cnt(glitch_cnt)
  );

  debounce_sync #(.GLITCH_WIDTH(2)) u_dut_g2 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout2), .rise(rise2), .fall(fall2), .stable(stable2),
    .glitch_cnt(glitch_cnt2)
  );

  typedef struct {
    logic dout;
    logic rise;
    logic fall;
    logic stable;
    int   glitch8;
    int   glitch2;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: delay line for the synchronizer, then a run length of
  // consecutive samples that disagree with the accepted level.
  logic m_pipe[$];
  logic m_dout;
  int   m_run;
  int   m_g8, m_g2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic d);
    exp_t e;
    logic s;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (r) begin
      m_pipe = {};
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
      m_dout = 1'b0;
      m_run  = 0;
      m_g8   = 0;
      m_g2   = 0;
    end else begin
      s = m_pipe[SYNC-1];
      m_pipe.push_front(d);
      void'(m_pipe.pop_back());
      if (s != m_dout) begin
        m_run++;
        if (m_run == DEB) begin
          m_dout = s;
          e.rise = s;
          e.fall = !s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        if (m_g8 < 255) m_g8++;
        if (m_g2 < 3) m_g2++;
        m_run = 0;
      end
    end
    e.dout    = m_dout;
    e.stable  = (m_run == 0);
    e.glitch8 = m_g8;
    e.glitch2 = m_g2;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus ahead of the next rising edge.
  task automatic step(input logic r, input logic d);
    @(negedge clk);
    rst = r;
    din = d;
    model_step(r, d);
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  // Hold din at d for n cycles and check that dout reaches d after exp_lat
  // edges, with the matching pulse on that cycle.
  task automatic hold_measure(input logic d, input int n, input int exp_lat,
                              input string name);
    int   lat = -1;
    logic pulse = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, d);
      @(posedge clk);
      #2;
      if (lat < 0 && dout == d) begin
        lat   = i + 1;
        pulse = d ? rise : fall;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_pulse"}, int'(pulse), 1);
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout", int'(dout), int'(e.dout));
        chk("rise", int'(rise), int'(e.rise));
        chk("fall", int'(fall), int'(e.fall));
        chk("stable", int'(stable), int'(e.stable));
        chk("glitch_cnt", int'(glitch_cnt), e.glitch8);
        chk("dout_g2", int'(dout2), int'(e.dout));
        chk("glitch_cnt_g2", int'(glitch_cnt2), e.glitch2);
        chk("stable_g2", int'(stable2), int'(e.stable));
      end
    end
  end

  initial begin
    int len;
    logic lvl;
    m_dout = 1'b0;
    m_run  = 0;
    m_g8   = 0;
    m_g2   = 0;

    // Reset with din high, then release; dout rises 10 edges after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold_measure(1'b1, 20, SYNC + DEB, "reset_release_rise");

    // Clean fall then clean rise and fall.
    hold_measure(1'b0, 20, SYNC + DEB, "clean_fall");
    hold_measure(1'b1, 20, SYNC + DEB, "clean_rise");
    hold_measure(1'b0, 20, SYNC + DEB, "clean_fall2");

    // Short glitches, three times.
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 5);
      hold(1'b0, 15);
    end

    // Exactly DEB sampled cycles is accepted; DEB-1 is rejected.
    hold(1'b1, DEB);
    hold(1'b0, 25);
    hold(1'b1, DEB - 1);
    hold(1'b0, 25);
    // Same boundary on the falling side.
    hold(1'b1, 25);
    hold(1'b0, DEB);
    hold(1'b1, 25);
    hold(1'b0, DEB - 1);
    hold(1'b1, 25);
    hold(1'b0, 25);

    // Reset in the middle of a count.
    hold(1'b1, 7);
    step(1'b1, 1'b1);
    hold(1'b0, 15);

    // Fast toggling saturates the 2-bit counter; dout never moves.
    for (int k = 0; k < 10; k++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    // Slow toggling is followed with the full latency.
    hold_measure(1'b1, 20, SYNC + DEB, "slow_rise");
    hold_measure(1'b0, 20, SYNC + DEB, "slow_fall");
    hold_measure(1'b1, 20, SYNC + DEB, "slow_rise2");
    hold_measure(1'b0, 20, SYNC + DEB, "slow_fall2");

    // Random runs with occasional resets.
    lvl = 1'b0;
    for (int k = 0; k < 400; k++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) step(1'b1, lvl);
      hold(lvl, len);
    end
    hold(1'b0, 20);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input before it drives a downstream D flip-flop's d input.
- Synchronizes the input through a flop chain, then debounces it with a counter-based FSM.
- Produces a clean level plus one-cycle rise/fall pulses.
- Counts rejected glitches for debug visibility.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4)
DEBOUNCE_CYCLES, 8, consecutive sampled cycles a new level must hold before acceptance (legal range 2..2^CNT_WIDTH-1)
CNT_WIDTH, 4, width of the debounce counter
GLITCH_WIDTH, 8, width of the glitch counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  1  raw asynchronous input
dout  output  1  debounced level (registered)
rise  output  1  one-cycle pulse when dout goes 0->1 (registered)
fall  output  1  one-cycle pulse when dout goes 1->0 (registered)
stable  output  1  high when the FSM is in S_LOW or S_HIGH
glitch_cnt  output  GLITCH_WIDTH  saturating count of aborted transitions

Behaviour:
- Reset:
  - rst sampled high at a clk edge clears the sync chain to 0, cnt=0, state=S_LOW.
  - Outputs after that edge: dout=0, rise=0, fall=0, stable=1, glitch_cnt=0.
  - rst has priority over every other event, including a reset mid-count.
- Synchronizer:
  - sync[0]<=din; sync[i]<=sync[i-1].
  - s = sync[SYNC_STAGES-1].
  - No logic other than the chain touches din.
- FSM states: S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L.
  - S_LOW: if s=1, go to S_WAIT_H and set cnt=1; else stay.
  - S_WAIT_H, s=0: go to S_LOW, cnt=0, glitch_cnt+1 (saturates at all-ones).
  - S_WAIT_H, s=1 and cnt==DEBOUNCE_CYCLES-1: go to S_HIGH, dout<=1, rise<=1, cnt=0.
  - S_WAIT_H, otherwise: cnt+1.
  - S_HIGH: if s=0, go to S_WAIT_L and set cnt=1; else stay.
  - S_WAIT_L mirrors S_WAIT_H with polarity inverted. Acceptance goes to S_LOW with dout<=0 and fall<=1; abort goes to S_HIGH with glitch_cnt+1.
- Pulses: rise and fall are high for exactly one cycle, coincident with the first cycle of the new dout value. They are never high together.
- stable is combinational from state: 0 in either WAIT state, 1 otherwise.
- Latency:
  - din captured high at edge E0 and held.
  - s=1 after edge E0+SYNC_STAGES-1.
  - dout=1 after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - With defaults, dout rises after edge E0+9. Falling latency is symmetric.
- Boundaries:
  - A glitch of fewer than DEBOUNCE_CYCLES sampled cycles never changes dout.
  - A pulse exactly DEBOUNCE_CYCLES sampled cycles long is accepted.
  - The counter never wraps, because DEBOUNCE_CYCLES-1 is at most the maximum count.
  - glitch_cnt holds at 2^GLITCH_WIDTH-1.

Test Plan:
1. Reset: hold rst=1 for 3 edges with din=1 -> dout=0, rise=0, fall=0, stable=1, glitch_cnt=0. Release rst with din=1 -> dout=1 and rise=1 for one cycle, 10 edges after release (defaults).
2. Clean rise then fall: din 0->1 held 20 cycles, then 1->0 held 20 cycles. Check each latency is 10 edges, with exactly one rise and one fall pulse. stable=0 for 7 cycles during each WAIT state.
3. Glitch rejection: din high for 5 cycles then low -> dout stays 0, no rise, glitch_cnt=1. Repeat 3 times -> glitch_cnt=3.
4. Exact-threshold pulse: s high for exactly 8 sampled cycles -> accepted, dout=1. s high for 7 cycles -> rejected, glitch_cnt+1.
5. Reset mid-count: assert rst while in S_WAIT_H with cnt=5 -> next cycle state=S_LOW, cnt=0, dout=0, glitch_cnt=0, no pulse.
6. Saturation and toggling: GLITCH_WIDTH=2, din toggling every 2 cycles for 40 cycles -> glitch_cnt reaches 3 and holds, dout stays 0. Then din toggling every 20 cycles -> dout follows with 10-edge latency and alternating rise/fall pulses.
